// File: rtl/fft_frame_pkg.sv
// ---------------------------------------------------------------------------
// fft_frame_pkg
// Shared definitions for the FFT framing buffer.
//   frame_state_t : framing FSM states (IDLE waits for a full frame,
//                   STREAM reads one frame out of the ring)
//   ptr_width()   : width of a ring pointer for a given ring depth; one extra
//                   bit beyond the address so that full and empty differ
// ---------------------------------------------------------------------------
package fft_frame_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } frame_state_t;

    // Pointers run modulo 2*depth: the address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fft_frame_buffer_ram.sv
// ---------------------------------------------------------------------------
// sample_ring_ram
// Simple dual-port sample store with one write port and one synchronous read
// port, written so that synthesis maps it onto block RAM.
//   clk     : clock for both ports
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : sample to store
//   rd_en   : read strobe; rd_data updates on the following edge
//   rd_addr : read address
//   rd_data : registered read data
// ---------------------------------------------------------------------------
module sample_ring_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    // No reset on the array or the read register: block RAM has none, and
    // the framing logic never consumes rd_data without a read having been
    // issued on the previous edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_frame_buffer.sv
// ---------------------------------------------------------------------------
// fft_frame_buffer
// Collects the audio sample stream in a circular RAM and replays it to the
// FFT core as frames of NSamples samples, oldest first. Successive frames
// start HOP samples apart, so with HOP < NSamples they overlap.
//   clk               : system clock
//   reset             : asynchronous, active-high reset
//   audio_input_valid : upstream sample valid
//   audio_input_ready : buffer can take a sample (ring not full)
//   audio_input_data  : upstream sample
//   fft_input         : sample presented to the FFT core
//   fft_input_valid   : fft_input holds a valid sample
//   fft_input_ready   : FFT core accepts the presented sample
//   fft_input_sop     : first sample of a frame (qualified by valid)
//   fft_input_eop     : last sample of a frame (qualified by valid)
//   fill_level        : samples held from the current frame base onward
// ---------------------------------------------------------------------------
module fft_frame_buffer
    import fft_frame_pkg::*;
#(
    parameter int W        = 16,
    parameter int NSamples = 1024,
    parameter int HOP      = 512,
    parameter int DEPTH    = 2 * NSamples
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   audio_input_valid,
    output logic                   audio_input_ready,
    input  logic [W-1:0]           audio_input_data,
    output logic [W-1:0]           fft_input,
    output logic                   fft_input_valid,
    input  logic                   fft_input_ready,
    output logic                   fft_input_sop,
    output logic                   fft_input_eop,
    output logic [$clog2(DEPTH):0] fill_level
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam int CW = $clog2(NSamples + 1);
    localparam int EW = W + 2;

    localparam logic [PW-1:0] DEPTH_P    = PW'(DEPTH);
    localparam logic [PW-1:0] NSAMPLES_P = PW'(NSamples);
    localparam logic [PW-1:0] HOP_P      = PW'(HOP);
    localparam logic [CW-1:0] NSAMPLES_C = CW'(NSamples);
    localparam logic [CW-1:0] LAST_IDX   = CW'(NSamples - 1);

    // Ring pointers (mod 2*DEPTH) and framing state
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] base_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] rd_cnt;
    frame_state_t  state;
    frame_state_t  next_state;

    // Read issue decisions made by the FSM output logic
    logic          rd_issue;
    logic [PW-1:0] rd_addr_ptr;
    logic          issue_sop;
    logic          issue_eop;

    // Read in flight: RAM data arrives on the edge after the read is issued
    logic          inflight;
    logic          inflight_sop;
    logic          inflight_eop;
    logic [W-1:0]  ram_q;
    logic [EW-1:0] ram_entry;

    // Two-entry output stage: head drives the outputs, skid absorbs the one
    // read that can still land after the FFT core stalls
    logic [EW-1:0] head_q;
    logic [EW-1:0] skid_q;
    logic [1:0]    occ;
    logic [1:0]    slots_used;
    logic          has_space;

    logic          wr_fire;
    logic          out_fire;
    logic          frame_done;
    logic          frame_ready;

    // Handshake and level bookkeeping. The ring only refuses input when the
    // oldest sample still needed by a frame would be overwritten, so output
    // backpressure reaches the input side only through fill_level.
    always_comb begin
        fill_level        = wr_ptr - base_ptr;
        audio_input_ready = (fill_level < DEPTH_P);
        wr_fire           = audio_input_valid && audio_input_ready;
        fft_input_valid   = (occ != 2'd0);
        fft_input         = head_q[W-1:0];
        fft_input_sop     = fft_input_valid && head_q[W+1];
        fft_input_eop     = fft_input_valid && head_q[W];
        out_fire          = fft_input_valid && fft_input_ready;
        frame_done        = out_fire && fft_input_eop;
        frame_ready       = (fill_level >= NSAMPLES_P);
        ram_entry         = {inflight_sop, inflight_eop, ram_q};
    end

    // A read may be issued only if its data is sure to find a free slot:
    // entries held plus the read already in flight, less the one leaving
    // this cycle, must stay below the two slots of the output stage.
    always_comb begin
        slots_used = occ + {1'b0, inflight};
        has_space  = (slots_used < 2'd2) || out_fire;
    end

    sample_ring_ram #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (audio_input_data),
        .rd_en   (rd_issue),
        .rd_addr (rd_addr_ptr[AW-1:0]),
        .rd_data (ram_q)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic: a frame starts once NSamples are held past the
    // base and ends when its last sample is taken by the FFT core.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (frame_ready) next_state = STREAM;
            STREAM:  if (frame_done)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM output logic. The first read of a frame is issued from IDLE on the
    // entry edge, straight from base_ptr, so that sample 0 reaches the output
    // two edges after the frame became complete. STREAM then reads the rest
    // in order, one per cycle while the output stage has room.
    always_comb begin
        rd_issue    = 1'b0;
        rd_addr_ptr = rd_ptr;
        issue_sop   = 1'b0;
        issue_eop   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_ready) begin
                    rd_issue    = 1'b1;
                    rd_addr_ptr = base_ptr;
                    issue_sop   = 1'b1;
                    issue_eop   = (NSamples == 1);
                end
            end
            STREAM: begin
                if ((rd_cnt < NSAMPLES_C) && has_space) begin
                    rd_issue  = 1'b1;
                    issue_eop = (rd_cnt == LAST_IDX);
                end
            end
            default: rd_issue = 1'b0;
        endcase
    end

    // Ring pointers. A write and a base advance on the same edge both take
    // effect, leaving fill_level at old + 1 - HOP. rd_cnt counts reads issued
    // for the current frame, so it doubles as the index of the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            base_ptr <= '0;
            rd_ptr   <= '0;
            rd_cnt   <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (frame_done) begin
                base_ptr <= base_ptr + HOP_P;
            end
            if (rd_issue) begin
                rd_ptr <= rd_addr_ptr + PW'(1);
                rd_cnt <= (state == IDLE) ? CW'(1) : rd_cnt + CW'(1);
            end
        end
    end

    // Frame markers travel alongside the read so they line up with the
    // RAM data when it lands in the output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight     <= 1'b0;
            inflight_sop <= 1'b0;
            inflight_eop <= 1'b0;
        end else begin
            inflight     <= rd_issue;
            inflight_sop <= issue_sop;
            inflight_eop <= issue_eop;
        end
    end

    // Output stage. The head changes only when it is empty or being taken,
    // which keeps fft_input, sop and eop stable while the core stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ    <= 2'd0;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            case (occ)
                2'd0: begin
                    if (inflight) begin
                        head_q <= ram_entry;
                        occ    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (out_fire && inflight) begin
                        head_q <= ram_entry;
                    end else if (out_fire) begin
                        occ <= 2'd0;
                    end else if (inflight) begin
                        skid_q <= ram_entry;
                        occ    <= 2'd2;
                    end
                end
                default: begin
                    if (out_fire) begin
                        head_q <= skid_q;
                        if (inflight) begin
                            skid_q <= ram_entry;
                        end else begin
                            occ <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
